// File: rtl/core_mem_arbiter_pkg.sv
// rtl/core_mem_arbiter_pkg.sv - shared widths and types for the two-core data-memory arbiter
package core_mem_arbiter_pkg;

  localparam int RW            = 16;
  localparam int ADDR_BYTES    = 2;
  localparam int ARB_PORTS     = 2;
  localparam int ARB_TIMEOUT_W = 8;

  typedef struct packed {
    logic                  we;
    logic [RW-1:0]         addr;
    logic [RW-1:0]         data;
    logic [ADDR_BYTES-1:0] sel;
    logic                  long_mode;
    logic [7:0]            addr_high;
  } bus_cmd_t;

  function automatic logic onehot_to_idx(input logic [ARB_PORTS-1:0] v);
    return v[1] & ~v[0];
  endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// rtl/core_mem_arbiter_if.sv - core-side request pins and system-bus master pins of the arbiter
interface core_mem_arbiter_if
  import core_mem_arbiter_pkg::*;
  ();

  logic [ARB_PORTS-1:0]            i_req;
  logic [ARB_PORTS-1:0]            i_we;
  logic [ARB_PORTS*RW-1:0]         i_addr;
  logic [ARB_PORTS*RW-1:0]         i_data;
  logic [ARB_PORTS*ADDR_BYTES-1:0] i_sel;
  logic [ARB_PORTS-1:0]            i_long;
  logic [ARB_PORTS*8-1:0]          i_addr_high;
  logic [ARB_PORTS-1:0]            o_ack;
  logic [RW-1:0]                   o_data;
  logic [ARB_PORTS-1:0]            o_exception;
  logic [ARB_PORTS-1:0]            o_grant;

  logic                            o_bus_req;
  logic                            o_bus_we;
  logic [RW-1:0]                   o_bus_addr;
  logic [RW-1:0]                   o_bus_data;
  logic [ADDR_BYTES-1:0]           o_bus_sel;
  logic                            o_bus_long;
  logic [7:0]                      o_bus_addr_high;
  logic [RW-1:0]                   i_bus_data;
  logic                            i_bus_ack;
  logic                            i_bus_exception;

  modport master (
    input  i_req, i_we, i_addr, i_data, i_sel, i_long, i_addr_high,
    input  i_bus_data, i_bus_ack, i_bus_exception,
    output o_ack, o_data, o_exception, o_grant,
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_data, o_bus_sel, o_bus_long, o_bus_addr_high
  );

  modport slave (
    output i_req, i_we, i_addr, i_data, i_sel, i_long, i_addr_high,
    output i_bus_data, i_bus_ack, i_bus_exception,
    input  o_ack, o_data, o_exception, o_grant,
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_data, o_bus_sel, o_bus_long, o_bus_addr_high
  );

endinterface

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - two-way round-robin pick; a tie goes to the core that did not win last
module arb_rr_pick
  import core_mem_arbiter_pkg::*;
(
  input  logic [ARB_PORTS-1:0] req,
  input  logic                 last_grant,
  output logic [ARB_PORTS-1:0] grant
);

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - round-robin arbiter sharing one data-memory bus between two cores
// Optional bus watchdog enabled by defining CORE_MEM_ARB_TIMEOUT_EN.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = (1 << ARB_TIMEOUT_W) - 1,
  parameter int FIRST_PRIO     = 0
) (
  input logic                i_clk,
  input logic                i_rst,
  core_mem_arbiter_if.master arb
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]           state;
  logic [ARB_PORTS-1:0] grant_q;
  logic [ARB_PORTS-1:0] pick;
  logic                 pick_idx;
  logic                 owner;
  logic                 last_grant;
  logic                 bus_req;
  logic                 busy;
  logic                 bus_done;
  logic                 timeout_hit;
  bus_cmd_t             cmd_q;
  bus_cmd_t             cmd_next;

  arb_rr_pick u_pick (
    .req        (arb.i_req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  assign pick_idx = onehot_to_idx(pick);
  assign owner    = onehot_to_idx(grant_q);
  assign busy     = (state == ST_BUSY);
  assign bus_done = busy && (arb.i_bus_ack || arb.i_bus_exception);

  always_comb begin
    cmd_next.we        = arb.i_we[pick_idx];
    cmd_next.addr      = arb.i_addr[pick_idx*RW +: RW];
    cmd_next.data      = arb.i_data[pick_idx*RW +: RW];
    cmd_next.sel       = arb.i_sel[pick_idx*ADDR_BYTES +: ADDR_BYTES];
    cmd_next.long_mode = arb.i_long[pick_idx];
    cmd_next.addr_high = arb.i_addr_high[pick_idx*8 +: 8];
  end

`ifdef CORE_MEM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Counter holds the number of silent BUSY cycles already elapsed, so the
  // current cycle is the last allowed one when it equals TIMEOUT_CYCLES-1.
  assign timeout_hit = busy && !bus_done && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || !busy) begin
      to_cnt <= '0;
    end else if (!bus_done) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      grant_q    <= '0;
      bus_req    <= 1'b0;
      cmd_q      <= '0;
      last_grant <= (FIRST_PRIO == 0) ? 1'b1 : 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|arb.i_req) begin
            cmd_q   <= cmd_next;
            grant_q <= pick;
            bus_req <= 1'b1;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus_done || timeout_hit) begin
            bus_req    <= 1'b0;
            grant_q    <= '0;
            last_grant <= owner;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Responses are steered to the owner only; a cycle with reset asserted never answers.
  always_comb begin
    arb.o_ack       = '0;
    arb.o_exception = '0;
    if (busy && !i_rst) begin
      arb.o_ack       = grant_q & {ARB_PORTS{arb.i_bus_ack}};
      arb.o_exception = grant_q & {ARB_PORTS{arb.i_bus_exception || timeout_hit}};
    end
  end

  assign arb.o_data          = arb.i_bus_data;
  assign arb.o_grant         = grant_q;
  assign arb.o_bus_req       = bus_req;
  assign arb.o_bus_we        = cmd_q.we;
  assign arb.o_bus_addr      = cmd_q.addr;
  assign arb.o_bus_data      = cmd_q.data;
  assign arb.o_bus_sel       = cmd_q.sel;
  assign arb.o_bus_long      = cmd_q.long_mode;
  assign arb.o_bus_addr_high = cmd_q.addr_high;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - directed self-checking bench for core_mem_arbiter
module tb_core_mem_arbiter;
  import core_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  core_mem_arbiter_if arb_if ();

  core_mem_arbiter #(
    .TIMEOUT_CYCLES (4),
    .FIRST_PRIO     (0)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .arb   (arb_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got still running, wanted finished");
    $fatal(1);
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int n, input logic we, input logic [15:0] addr,
                          input logic [15:0] data, input logic [1:0] sel,
                          input logic lng, input logic [7:0] ah);
    arb_if.i_we[n]             = we;
    arb_if.i_addr[n*16 +: 16]  = addr;
    arb_if.i_data[n*16 +: 16]  = data;
    arb_if.i_sel[n*2 +: 2]     = sel;
    arb_if.i_long[n]           = lng;
    arb_if.i_addr_high[n*8 +: 8] = ah;
  endtask

  logic [1:0] exp_g;

  initial begin
    arb_if.i_req           = '0;
    arb_if.i_we            = '0;
    arb_if.i_addr          = '0;
    arb_if.i_data          = '0;
    arb_if.i_sel           = '0;
    arb_if.i_long          = '0;
    arb_if.i_addr_high     = '0;
    arb_if.i_bus_data      = '0;
    arb_if.i_bus_ack       = 1'b0;
    arb_if.i_bus_exception = 1'b0;

    tick();
    tick();
    rst = 1'b0;
    expect_eq("rst_bus_req", arb_if.o_bus_req, 0);
    expect_eq("rst_grant", arb_if.o_grant, 0);
    expect_eq("rst_ack", arb_if.o_ack, 0);
    expect_eq("rst_exc", arb_if.o_exception, 0);
    expect_eq("rst_bus_addr", arb_if.o_bus_addr, 0);
    tick();
    expect_eq("idle_no_req", arb_if.o_bus_req, 0);

    // core 0 read, ack after three bus cycles
    set_core(0, 1'b0, 16'h1234, 16'h0000, 2'b11, 1'b0, 8'h00);
    arb_if.i_req = 2'b01;
    tick();
    expect_eq("c0_bus_req", arb_if.o_bus_req, 1);
    expect_eq("c0_bus_addr", arb_if.o_bus_addr, 32'h1234);
    expect_eq("c0_bus_we", arb_if.o_bus_we, 0);
    expect_eq("c0_grant", arb_if.o_grant, 2'b01);
    expect_eq("c0_no_ack_c1", arb_if.o_ack, 0);
    tick();
    expect_eq("c0_no_ack_c2", arb_if.o_ack, 0);
    tick();
    expect_eq("c0_no_ack_c3", arb_if.o_ack, 0);
    arb_if.i_bus_ack  = 1'b1;
    arb_if.i_bus_data = 16'hBEEF;
    #1;
    expect_eq("c0_ack", arb_if.o_ack, 2'b01);
    expect_eq("c0_rdata", arb_if.o_data, 32'hBEEF);
    expect_eq("c0_exc", arb_if.o_exception, 0);
    tick();
    arb_if.i_bus_ack = 1'b0;
    arb_if.i_req     = 2'b00;
    expect_eq("c0_done_req", arb_if.o_bus_req, 0);
    expect_eq("c0_done_grant", arb_if.o_grant, 0);

    // both cores continuously requesting: grants alternate starting with core 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_core(0, 1'b0, 16'h0100, 16'h0000, 2'b11, 1'b0, 8'h00);
    set_core(1, 1'b0, 16'h0200, 16'h0000, 2'b11, 1'b0, 8'h00);
    arb_if.i_req = 2'b11;
    exp_g = 2'b01;
    for (int k = 0; k < 4; k++) begin
      tick();
      arb_if.i_req = 2'b11;
      expect_eq($sformatf("rr%0d_grant", k), arb_if.o_grant, exp_g);
      expect_eq($sformatf("rr%0d_bus_req", k), arb_if.o_bus_req, 1);
      expect_eq($sformatf("rr%0d_addr", k), arb_if.o_bus_addr, (exp_g == 2'b01) ? 32'h0100 : 32'h0200);
      arb_if.i_bus_ack = 1'b1;
      #1;
      expect_eq($sformatf("rr%0d_ack", k), arb_if.o_ack, exp_g);
      tick();
      arb_if.i_bus_ack = 1'b0;
      arb_if.i_req     = arb_if.i_req & ~exp_g;
      expect_eq($sformatf("rr%0d_gap", k), arb_if.o_bus_req, 0);
      exp_g = ~exp_g;
    end
    arb_if.i_req = 2'b00;
    tick();

    // core 1 long write; core 0 inputs change while core 1 owns the bus
    set_core(1, 1'b1, 16'h0300, 16'h00AA, 2'b01, 1'b1, 8'h7F);
    arb_if.i_req = 2'b10;
    tick();
    expect_eq("wr_grant", arb_if.o_grant, 2'b10);
    expect_eq("wr_we", arb_if.o_bus_we, 1);
    expect_eq("wr_data", arb_if.o_bus_data, 32'h00AA);
    expect_eq("wr_sel", arb_if.o_bus_sel, 2'b01);
    expect_eq("wr_long", arb_if.o_bus_long, 1);
    expect_eq("wr_ah", arb_if.o_bus_addr_high, 8'h7F);
    set_core(0, 1'b0, 16'hFFFF, 16'h5555, 2'b10, 1'b0, 8'h11);
    arb_if.i_req = 2'b11;
    tick();
    tick();
    expect_eq("wr_hold_addr", arb_if.o_bus_addr, 32'h0300);
    expect_eq("wr_hold_data", arb_if.o_bus_data, 32'h00AA);
    expect_eq("wr_hold_we", arb_if.o_bus_we, 1);
    expect_eq("wr_hold_grant", arb_if.o_grant, 2'b10);
    arb_if.i_bus_ack = 1'b1;
    #1;
    expect_eq("wr_ack", arb_if.o_ack, 2'b10);
    tick();
    arb_if.i_bus_ack = 1'b0;
    arb_if.i_req     = 2'b01;
    tick();
    expect_eq("wr_next_grant", arb_if.o_grant, 2'b01);
    expect_eq("wr_next_addr", arb_if.o_bus_addr, 32'hFFFF);
    arb_if.i_bus_ack = 1'b1;
    tick();
    arb_if.i_bus_ack = 1'b0;
    arb_if.i_req     = 2'b00;
    tick();

    // bus exception on a core 0 read
    set_core(0, 1'b0, 16'h4444, 16'h0000, 2'b11, 1'b0, 8'h00);
    arb_if.i_req = 2'b01;
    tick();
    arb_if.i_bus_exception = 1'b1;
    #1;
    expect_eq("exc_exc", arb_if.o_exception, 2'b01);
    expect_eq("exc_ack", arb_if.o_ack, 2'b00);
    tick();
    arb_if.i_bus_exception = 1'b0;
    arb_if.i_req           = 2'b00;
    expect_eq("exc_idle_req", arb_if.o_bus_req, 0);
    expect_eq("exc_idle_grant", arb_if.o_grant, 0);
    arb_if.i_req = 2'b11;
    tick();
    expect_eq("exc_next_tie", arb_if.o_grant, 2'b10);
    arb_if.i_bus_ack = 1'b1;
    tick();
    arb_if.i_bus_ack = 1'b0;
    arb_if.i_req     = 2'b00;
    tick();

    // reset two cycles into a transaction
    set_core(0, 1'b0, 16'h2222, 16'h0000, 2'b11, 1'b0, 8'h00);
    arb_if.i_req = 2'b01;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    arb_if.i_req = 2'b00;
    expect_eq("mid_rst_req", arb_if.o_bus_req, 0);
    expect_eq("mid_rst_grant", arb_if.o_grant, 0);
    expect_eq("mid_rst_addr", arb_if.o_bus_addr, 0);
    arb_if.i_bus_ack = 1'b1;
    #1;
    expect_eq("mid_rst_late_ack", arb_if.o_ack, 0);
    expect_eq("mid_rst_late_exc", arb_if.o_exception, 0);
    tick();
    arb_if.i_bus_ack = 1'b0;
    expect_eq("mid_rst_stay_idle", arb_if.o_bus_req, 0);

`ifdef CORE_MEM_ARB_TIMEOUT_EN
    // silent bus: exception in the fourth BUSY cycle
    arb_if.i_req = 2'b01;
    for (int c = 1; c <= 3; c++) begin
      tick();
      expect_eq($sformatf("to_quiet_c%0d", c), arb_if.o_exception, 0);
    end
    tick();
    expect_eq("to_exc", arb_if.o_exception, 2'b01);
    expect_eq("to_ack", arb_if.o_ack, 2'b00);
    tick();
    arb_if.i_req = 2'b00;
    expect_eq("to_req_drop", arb_if.o_bus_req, 0);
    expect_eq("to_grant_drop", arb_if.o_grant, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
